// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path.
//   UART_DATA_W : default data width, matches the uart block's din.
//   tx_state_e  : drain FSM states of uart_tx_fifo.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT_BUSY,
    WAIT_DONE
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// uart_sync_fifo: circular buffer with registered occupancy flags.
// Ports:
//   clk_50m, rst_n : clock, async active-low reset
//   flush          : synchronous clear, wins over push/pop
//   push, wr_data  : enqueue (ignored while full)
//   pop            : dequeue head (ignored while empty)
//   rd_data        : current head, combinational from storage
//   count/empty/full : registered occupancy, reflect the previous edge
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = UART_DATA_W,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic             clk_50m,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count_nxt;
  logic             push_ok, pop_ok;

  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty && !flush;
  assign rd_data = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (flush)
      count_nxt = '0;
    else if (push_ok && !pop_ok)
      count_nxt = count + 1'b1;
    else if (pop_ok && !push_ok)
      count_nxt = count - 1'b1;
  end

  // Pointers wrap naturally: DEPTH is a power of two and they are AW bits.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + 1'b1;
        if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count_nxt;
      empty <= (count_nxt == '0);
      full  <= (count_nxt == CW'(DEPTH));
    end
  end

  // Storage needs no reset: nothing is read until a push makes it valid.
  always_ff @(posedge clk_50m) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffers bytes from a valid/ready producer and drains them
// one at a time into the uart transmitter whenever it is idle.
// Ports:
//   clk_50m, rst_n   : clock, async active-low reset
//   s_data/s_valid/s_ready : producer side, s_ready = !full
//   flush            : synchronous clear of FIFO and drain FSM
//   din, wr_en       : registered one-cycle write strobe + data to uart
//   tx_busy          : uart transmitter busy
//   count/empty/full : FIFO occupancy
//   ovf_cnt          : saturating dropped-write counter, only when
//                      UART_TX_FIFO_OVF_CNT_EN is defined
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH     = UART_DATA_W,
  parameter int DEPTH     = 16,
  parameter int BUSY_WAIT = 4,
  localparam int CW       = $clog2(DEPTH) + 1,
  localparam int BW       = (BUSY_WAIT > 1) ? $clog2(BUSY_WAIT) : 1
) (
  input  logic             clk_50m,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             flush,
  output logic [WIDTH-1:0] din,
  output logic             wr_en,
  input  logic             tx_busy,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full
`ifdef UART_TX_FIFO_OVF_CNT_EN
  ,
  output logic [7:0]       ovf_cnt
`endif
);

  tx_state_e        state, state_nxt;
  logic [BW-1:0]    bw_cnt;
  logic [WIDTH-1:0] head;

  assign s_ready = !full;

  // Pop happens on the edge that leaves LOAD; the FIFO masks it under flush.
  uart_sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_50m (clk_50m),
    .rst_n   (rst_n),
    .flush   (flush),
    .push    (s_valid),
    .wr_data (s_data),
    .pop     (state == LOAD),
    .rd_data (head),
    .count   (count),
    .empty   (empty),
    .full    (full)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (!empty && !tx_busy) state_nxt = LOAD;
      LOAD:      state_nxt = WAIT_BUSY;
      // If the uart never acknowledges, give up and treat the byte as sent.
      WAIT_BUSY: if (tx_busy)                           state_nxt = WAIT_DONE;
                 else if (bw_cnt == BW'(BUSY_WAIT - 1)) state_nxt = IDLE;
      WAIT_DONE: if (!tx_busy) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  // wr_en/din are registered from the next state, so the strobe is high
  // exactly while the FSM sits in LOAD.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      wr_en  <= 1'b0;
      din    <= '0;
      bw_cnt <= '0;
    end else begin
      state <= state_nxt;
      wr_en <= (state_nxt == LOAD);
      if (state_nxt == LOAD) din <= head;
      bw_cnt <= (state == WAIT_BUSY) ? bw_cnt + 1'b1 : '0;
    end
  end

`ifdef UART_TX_FIFO_OVF_CNT_EN
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n)
      ovf_cnt <= '0;
    else if (flush)
      ovf_cnt <= '0;
    else if (s_valid && full && ovf_cnt != 8'hFF)
      ovf_cnt <= ovf_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: queue-based reference model checked every cycle,
// a small behavioural uart responder, and directed scenarios with literal
// expectations. Honors UART_TX_FIFO_OVF_CNT_EN when defined.
module tb_uart_tx_fifo;

  localparam int DEPTH     = 16;
  localparam int BUSY_WAIT = 4;
  localparam int CW        = $clog2(DEPTH) + 1;
  localparam int FRAME     = 10;

  logic          clk_50m = 1'b0;
  logic          rst_n   = 1'b0;
  logic [7:0]    s_data  = '0;
  logic          s_valid = 1'b0;
  logic          flush   = 1'b0;
  logic          tx_busy = 1'b0;
  logic          s_ready, wr_en, empty, full;
  logic [7:0]    din;
  logic [CW-1:0] count;
`ifdef UART_TX_FIFO_OVF_CNT_EN
  logic [7:0]    ovf_cnt;
`endif

  always #5 clk_50m = ~clk_50m;

  uart_tx_fifo #(
    .WIDTH     (8),
    .DEPTH     (DEPTH),
    .BUSY_WAIT (BUSY_WAIT)
  ) dut (
    .clk_50m (clk_50m),
    .rst_n   (rst_n),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .flush   (flush),
    .din     (din),
    .wr_en   (wr_en),
    .tx_busy (tx_busy),
    .count   (count),
    .empty   (empty),
    .full    (full)
`ifdef UART_TX_FIFO_OVF_CNT_EN
    ,
    .ovf_cnt (ovf_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_50m);
      #1;
    end
  endtask

  // uart stand-in: mode 0 = busy for FRAME cycles starting the edge after a
  // strobe, 1 = busy forced high, 2 = busy tied low.
  int         mode = 0;
  int         busy_left = 0;
  bit         pend = 0;
  logic [7:0] rx_q[$];

  always @(posedge clk_50m) begin
    #2;
    if (pend) begin
      pend = 0;
      busy_left = FRAME;
    end
    if (wr_en === 1'b1) begin
      pend = 1;
      rx_q.push_back(din);
    end
    case (mode)
      1: begin tx_busy = 1'b1; busy_left = 0; end
      2: begin tx_busy = 1'b0; busy_left = 0; end
      default: begin
        if (busy_left > 0) begin
          tx_busy = 1'b1;
          busy_left--;
        end else begin
          tx_busy = 1'b0;
        end
      end
    endcase
  end

  // Reference model: FIFO contents as a queue, drop counter as an int.
  logic [7:0]  mq[$];
  int          movf = 0;
  int          cyc = 0;
  int          n_pulse = 0;
  int          last_pulse = -100;
  int          gap = 0;
  bit          prev_wr = 0, prev_busy = 0, no_wr_next = 0, push_ok;
  logic [31:0] exp_din;

  always @(posedge clk_50m) cyc++;

  always @(negedge clk_50m) begin
    if (!rst_n) begin
      mq.delete();
      movf = 0;
      prev_wr = 0;
      prev_busy = 0;
      no_wr_next = 0;
      chk("rst_wr_en", 32'(wr_en), 32'(0));
      chk("rst_din",   32'(din),   32'(0));
      chk("rst_count", 32'(count), 32'(0));
      chk("rst_empty", 32'(empty), 32'(1));
      chk("rst_full",  32'(full),  32'(0));
    end else begin
      chk("count",   32'(count),   32'(mq.size()));
      chk("empty",   32'(empty),   32'(mq.size() == 0));
      chk("full",    32'(full),    32'(mq.size() == DEPTH));
      chk("s_ready", 32'(s_ready), 32'(mq.size() != DEPTH));
`ifdef UART_TX_FIFO_OVF_CNT_EN
      chk("ovf_cnt", 32'(ovf_cnt), 32'(movf));
`endif
      if (no_wr_next) chk("wr_en_after_flush", 32'(wr_en), 32'(0));
      if (wr_en === 1'b1) begin
        chk("wr_en_back_to_back", 32'(prev_wr), 32'(0));
        chk("wr_en_rise_busy", 32'(prev_busy), 32'(0));
        exp_din = (mq.size() > 0) ? 32'(mq[0]) : 32'h100;
        chk("din_head", 32'(din), exp_din);
        n_pulse++;
        gap = cyc - last_pulse;
        last_pulse = cyc;
      end
      // predict the coming edge
      no_wr_next = flush;
      if (flush) begin
        mq.delete();
        movf = 0;
      end else begin
        push_ok = s_valid && (mq.size() < DEPTH);
        if (s_valid && mq.size() == DEPTH && movf < 255) movf++;
        if (wr_en === 1'b1 && mq.size() > 0) void'(mq.pop_front());
        if (push_ok) mq.push_back(s_data);
      end
      prev_wr = wr_en;
      prev_busy = tx_busy;
    end
  end

  int i, t, p0;
  bit acc;

  initial begin
    // reset
    tick(3);
    chk("reset_s_ready", 32'(s_ready), 32'(1));
    chk("reset_empty",   32'(empty),   32'(1));
    rst_n = 1'b1;
    tick(2);

    // first-byte latency: accept at edge k, strobe after k+1, gone after k+2
    mode = 0;
    s_valid = 1'b1;
    s_data  = 8'hA5;
    tick(1);
    s_valid = 1'b0;
    chk("lat_empty",  32'(empty), 32'(0));
    chk("lat_count",  32'(count), 32'(1));
    chk("lat_wr_k",   32'(wr_en), 32'(0));
    tick(1);
    chk("lat_wr_k1",  32'(wr_en), 32'(1));
    chk("lat_din",    32'(din),   32'hA5);
    tick(1);
    chk("lat_wr_k2",  32'(wr_en), 32'(0));
    chk("lat_count2", 32'(count), 32'(0));
    tick(20);

    // loopback burst 0x00..0xFF honoring s_ready
    rx_q.delete();
    p0 = n_pulse;
    i = 0;
    t = 0;
    s_valid = 1'b1;
    s_data  = 8'h00;
    while (i < 256 && t < 8000) begin
      acc = s_ready;
      tick(1);
      t++;
      if (acc) begin
        i++;
        s_data = 8'(i);
      end
    end
    s_valid = 1'b0;
    chk("lb_accepted", 32'(i), 32'(256));
    t = 0;
    while (rx_q.size() < 256 && t < 8000) begin
      tick(1);
      t++;
    end
    chk("lb_rx_size", 32'(rx_q.size()), 32'(256));
    for (int k = 0; k < rx_q.size(); k++) chk("lb_rx_byte", 32'(rx_q[k]), 32'(k));
    tick(20);
    chk("lb_pulses", 32'(n_pulse - p0), 32'(256));
    chk("lb_count",  32'(count), 32'(0));

    // busy never rises: each byte times out after BUSY_WAIT cycles
    mode = 2;
    tick(3);
    p0 = n_pulse;
    s_valid = 1'b1;
    s_data  = 8'h3C;
    tick(1);
    s_data  = 8'h3D;
    tick(1);
    s_valid = 1'b0;
    tick(15);
    chk("to_pulses", 32'(n_pulse - p0), 32'(2));
    chk("to_gap",    32'(gap), 32'(2 + BUSY_WAIT));
    chk("to_count",  32'(count), 32'(0));

    // fill with the uart held busy: DEPTH+3 offered, 3 dropped
    mode = 1;
    tick(2);
    s_valid = 1'b1;
    for (int k = 0; k < DEPTH + 3; k++) begin
      s_data = 8'(8'h80 + k);
      tick(1);
    end
    s_valid = 1'b0;
    chk("fill_full",    32'(full),    32'(1));
    chk("fill_s_ready", 32'(s_ready), 32'(0));
    chk("fill_count",   32'(count),   32'(16));
`ifdef UART_TX_FIFO_OVF_CNT_EN
    chk("fill_ovf", 32'(ovf_cnt), 32'(3));
`endif
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    chk("flush_count", 32'(count), 32'(0));
    chk("flush_empty", 32'(empty), 32'(1));
`ifdef UART_TX_FIFO_OVF_CNT_EN
    chk("flush_ovf", 32'(ovf_cnt), 32'(0));
`endif

    // simultaneous push and pop at count = 5
    s_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      s_data = 8'(8'h50 + k);
      tick(1);
    end
    s_valid = 1'b0;
    chk("sp_count_pre", 32'(count), 32'(5));
    mode = 0;
    t = 0;
    while (wr_en !== 1'b1 && t < 40) begin
      tick(1);
      t++;
    end
    chk("sp_wr_en", 32'(wr_en), 32'(1));
    chk("sp_din",   32'(din),   32'h50);
    s_valid = 1'b1;
    s_data  = 8'h55;
    tick(1);
    chk("sp_count", 32'(count), 32'(5));
    s_data  = 8'h56;
    tick(1);
    s_data  = 8'h57;
    tick(1);
    s_valid = 1'b0;
    chk("fl_count_pre", 32'(count), 32'(7));

    // flush while the uart is mid-frame (WAIT_DONE)
    t = 0;
    while (tx_busy !== 1'b1 && t < 40) begin
      tick(1);
      t++;
    end
    chk("fl_busy_seen", 32'(t < 40), 32'(1));
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    chk("fl_count", 32'(count), 32'(0));
    chk("fl_wr_en", 32'(wr_en), 32'(0));
    p0 = n_pulse;
    t = 0;
    while (tx_busy !== 1'b0 && t < 40) begin
      tick(1);
      t++;
    end
    tick(15);
    chk("fl_no_wr", 32'(n_pulse - p0), 32'(0));

    // asynchronous reset mid-frame with bytes queued
    s_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      s_data = 8'(8'hC0 + k);
      tick(1);
    end
    s_valid = 1'b0;
    t = 0;
    while (tx_busy !== 1'b1 && t < 40) begin
      tick(1);
      t++;
    end
    tick(2);
    chk("ar_count_pre", 32'(count), 32'(3));
    rst_n = 1'b0;
    #1;
    chk("ar_wr_en",   32'(wr_en),   32'(0));
    chk("ar_din",     32'(din),     32'(0));
    chk("ar_count",   32'(count),   32'(0));
    chk("ar_empty",   32'(empty),   32'(1));
    chk("ar_full",    32'(full),    32'(0));
    chk("ar_s_ready", 32'(s_ready), 32'(1));
    tick(2);
    rst_n = 1'b1;
    p0 = n_pulse;
    tick(25);
    chk("ar_no_wr",     32'(n_pulse - p0), 32'(0));
    chk("ar_count_end", 32'(count), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
